tx_fifo: RTL

TX_FIFO -- requirements
Module: tx_fifo

---
 rtl/uart_pkg.sv | 19 +
 rtl/tx_fifo_if.sv | 37 +++
 rtl/fifo_mem.sv | 28 ++
 rtl/tx_fifo.sv | 88 ++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data/FIFO geometry and TX FSM encodings.
// Imported by the TX FIFO, its storage and its handshake interface.
package uart_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef enum logic [2:0] {
    INTERVAL  = 3'd0,
    STARTBIT  = 3'd1,
    DATABITS  = 3'd2,
    PARITYBIT = 3'd3,
    STOPBIT   = 3'd4
  } txState_t;

  typedef logic [DATA_WIDTH-1:0] txChar_t;

endpackage

// File: rtl/tx_fifo_if.sv
// Host/TX-shifter handshake bundle around the TX FIFO.
// master drives strobes and data, slave is the FIFO itself.
interface tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DW = uart_pkg::DATA_WIDTH,
  parameter int AW = uart_pkg::ADDR_WIDTH
);

  logic          n_FifoWe_i;
  logic [DW-1:0] WrData_i;
  logic          n_FifoRe_i;
  logic          p_ErrClear_i;
  logic          p_FifoFull_o;
  logic [DW-1:0] FifoData_o;
  logic          p_FiFoEmpty_o;
  logic [AW:0]   FifoCount_o;
  logic          p_Overflow_o;
  logic          p_Underflow_o;

  modport master (
    output n_FifoWe_i, WrData_i,
    output n_FifoRe_i, p_ErrClear_i,
    input  p_FifoFull_o, FifoData_o,
    input  p_FiFoEmpty_o, FifoCount_o,
    input  p_Overflow_o, p_Underflow_o
  );

  modport slave (
    input  n_FifoWe_i, WrData_i,
    input  n_FifoRe_i, p_ErrClear_i,
    output p_FifoFull_o, FifoData_o,
    output p_FiFoEmpty_o, FifoCount_o,
    output p_Overflow_o, p_Underflow_o
  );

endinterface

// File: rtl/fifo_mem.sv
// TX FIFO storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
  parameter int DEPTH      = uart_pkg::DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic [ADDR_WIDTH-1:0] rAddr,
  output logic [DATA_WIDTH-1:0] rData
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wAddr] <= wData;
    end
  end

  assign rData = mem[rAddr];

endmodule

// File: rtl/tx_fifo.sv
// First-word-fall-through TX FIFO with sticky over/underflow flags.
// Pointer, count and flag control; storage lives in fifo_mem.
module tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
  parameter int DEPTH      = uart_pkg::DEPTH
) (
  input logic     clk,
  input logic     rst,
  tx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0]         wrPtr;
  logic [AW-1:0]         rdPtr;
  logic [AW:0]           count;
  logic                  ovf;
  logic                  unf;
  logic [DATA_WIDTH-1:0] memData;

  logic empty, full;
  logic wrReq, rdReq;
  logic wrOk, rdOk;
  logic ovfEv, unfEv;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign wrReq = ~bus.n_FifoWe_i;
  assign rdReq = ~bus.n_FifoRe_i;

  // A pop in the same cycle frees the slot a full-FIFO write needs.
  assign rdOk  = rdReq & ~empty;
  assign wrOk  = wrReq & (~full | rdOk);
  assign ovfEv = wrReq & full & ~rdOk;
  assign unfEv = rdReq & empty;

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW)
  ) u_mem (
    .clk  (clk),
    .we   (wrOk & ~rst),
    .wAddr(wrPtr),
    .wData(bus.WrData_i),
    .rAddr(rdPtr),
    .rData(memData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (wrOk) wrPtr <= wrPtr + PTR_ONE;
      if (rdOk) rdPtr <= rdPtr + PTR_ONE;
      unique case (1'b1)
        (wrOk & ~rdOk): count <= count + CNT_ONE;
        (rdOk & ~wrOk): count <= count - CNT_ONE;
        default:        count <= count;
      endcase
      // A fresh error event outranks the clear pulse.
      if (bus.p_ErrClear_i) begin
        ovf <= ovfEv;
        unf <= unfEv;
      end else begin
        ovf <= ovf | ovfEv;
        unf <= unf | unfEv;
      end
    end
  end

  assign bus.FifoData_o    = empty ? '0 : memData;
  assign bus.p_FiFoEmpty_o = empty;
  assign bus.p_FifoFull_o  = full;
  assign bus.FifoCount_o   = count;
  assign bus.p_Overflow_o  = ovf;
  assign bus.p_Underflow_o = unf;

endmodule
